// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WRITEBACK sequencer owning the PC, with jump handling and halt-on-zero.
// Define PC_SEQ_DELAY_SLOT_EN for MIPS delay-slot semantics; otherwise jumps apply in their own WRITEBACK.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_in,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        mem_waitrequest,
  input  logic        stall_req,
  output logic [3:0]  state,
  output logic [31:0] pc,
  output logic        mem_read,
  output logic        ir_write,
  output logic        reg_write_en,
  output logic        in_delay_slot,
  output logic        active
);

  localparam logic [3:0] FETCH     = 4'b0000;
  localparam logic [3:0] DECODE    = 4'b0001;
  localparam logic [3:0] EXEC      = 4'b0010;
  localparam logic [3:0] WRITEBACK = 4'b0011;
  localparam logic [3:0] HALT      = 4'b1111;

  logic        pending;
  logic [31:0] target_q;
  logic        take_jump;

  // A jump is only accepted once per pending window, and only on the non-stalled EXEC cycle.
  assign take_jump = (state == EXEC) && !stall_req && jump_en && jump_in && !pending;

`ifdef PC_SEQ_DELAY_SLOT_EN
  logic delay_slot;

  // Sequencer state, PC and pending-jump bookkeeping with delay slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      pending    <= 1'b0;
      target_q   <= 32'd0;
      delay_slot <= 1'b0;
    end else begin
      case (state)
        FETCH:     if (!mem_waitrequest) state <= DECODE;
        DECODE:    state <= EXEC;
        EXEC: begin
          if (!stall_req) state <= WRITEBACK;
          if (take_jump) begin
            target_q <= jump_target;
            pending  <= 1'b1;
          end
        end
        WRITEBACK: begin
          // The jump lands only after the following (delay-slot) instruction retires.
          if (delay_slot) begin
            pc         <= target_q;
            pending    <= 1'b0;
            delay_slot <= 1'b0;
            state      <= (target_q == 32'd0) ? HALT : FETCH;
          end else begin
            pc         <= pc + 32'd4;
            delay_slot <= pending;
            state      <= FETCH;
          end
        end
        HALT:      state <= HALT;
        default:   state <= FETCH;
      endcase
    end
  end

  assign in_delay_slot = delay_slot;
`else
  // Sequencer state, PC and jump bookkeeping; a taken jump applies in its own WRITEBACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_VECTOR;
      pending  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      case (state)
        FETCH:     if (!mem_waitrequest) state <= DECODE;
        DECODE:    state <= EXEC;
        EXEC: begin
          if (!stall_req) state <= WRITEBACK;
          if (take_jump) begin
            target_q <= jump_target;
            pending  <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pending) begin
            pc      <= target_q;
            pending <= 1'b0;
            state   <= (target_q == 32'd0) ? HALT : FETCH;
          end else begin
            pc      <= pc + 32'd4;
            state   <= FETCH;
          end
        end
        HALT:      state <= HALT;
        default:   state <= FETCH;
      endcase
    end
  end

  assign in_delay_slot = 1'b0;
`endif

  assign mem_read     = (state == FETCH);
  assign ir_write     = (state == FETCH) && !mem_waitrequest;
  assign reg_write_en = (state == WRITEBACK);
  assign active       = (state != HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against an instruction-level model of PC/jump behaviour.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;
`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_in = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        mem_waitrequest = 1'b0;
  logic        stall_req = 1'b0;
  logic [3:0]  state;
  logic [31:0] pc;
  logic        mem_read, ir_write, reg_write_en, in_delay_slot, active;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .jump_in(jump_in), .jump_en(jump_en),
    .jump_target(jump_target), .mem_waitrequest(mem_waitrequest), .stall_req(stall_req),
    .state(state), .pc(pc), .mem_read(mem_read), .ir_write(ir_write),
    .reg_write_en(reg_write_en), .in_delay_slot(in_delay_slot), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Instruction-level model: current pc, pending target, delay-slot flag, halted.
  logic [31:0] m_pc, m_tgt;
  bit          m_pend, m_ds, m_halt;

  task automatic model_reset();
    m_pc = RV; m_tgt = 32'd0; m_pend = 1'b0; m_ds = 1'b0; m_halt = 1'b0;
  endtask

  task automatic clear_inputs();
    jump_in = 1'b0; jump_en = 1'b0; jump_target = 32'd0;
    stall_req = 1'b0; mem_waitrequest = 1'b0;
  endtask

  // Execute one instruction; checks each cycle. Called and returns at a negedge.
  task automatic run_instr(input int waits, input int stalls, input bit jmp, input logic [31:0] tgt);
    logic [31:0] new_pc;
    bit apply, exp_ds;
    logic [3:0] exp_st;
    exp_ds = DS && m_ds;
    for (int i = 0; i <= waits; i++) begin
      mem_waitrequest = (i < waits);
      #1;
      n_checks++;
      if (state !== 4'h0 || mem_read !== 1'b1 || ir_write !== (i == waits) || reg_write_en !== 1'b0 ||
          pc !== m_pc || in_delay_slot !== exp_ds || active !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch[%0d]: state=%h pc=%h mr=%b irw=%b rwe=%b ds=%b act=%b; need state=0 pc=%h mr=1 irw=%b rwe=0 ds=%b act=1",
                 i, state, pc, mem_read, ir_write, reg_write_en, in_delay_slot, active, m_pc, (i == waits), exp_ds);
      end
      @(negedge clk);
    end
    // DECODE: jump inputs and waitrequest must be ignored here
    mem_waitrequest = 1'($urandom_range(0, 1));
    jump_en = 1'b1; jump_in = 1'b1; jump_target = ~tgt;
    #1;
    n_checks++;
    if (state !== 4'h1 || mem_read !== 1'b0 || ir_write !== 1'b0 || reg_write_en !== 1'b0 ||
        pc !== m_pc || in_delay_slot !== exp_ds) begin
      n_fail++;
      $display("FAIL decode: state=%h pc=%h mr=%b irw=%b rwe=%b ds=%b; need state=1 pc=%h strobes=0 ds=%b",
               state, pc, mem_read, ir_write, reg_write_en, in_delay_slot, m_pc, exp_ds);
    end
    @(negedge clk);
    for (int i = 0; i <= stalls; i++) begin
      stall_req = (i < stalls);
      if (i < stalls) begin
        jump_en = 1'b1; jump_in = 1'b1; jump_target = ~tgt;
      end else begin
        jump_en = jmp ? 1'b1 : 1'($urandom_range(0, 1));
        jump_in = jmp ? 1'b1 : (jump_en ? 1'b0 : 1'($urandom_range(0, 1)));
        jump_target = tgt;
      end
      #1;
      n_checks++;
      if (state !== 4'h2 || mem_read !== 1'b0 || ir_write !== 1'b0 || reg_write_en !== 1'b0 ||
          pc !== m_pc || in_delay_slot !== exp_ds) begin
        n_fail++;
        $display("FAIL exec[%0d]: state=%h pc=%h rwe=%b ds=%b; need state=2 pc=%h rwe=0 ds=%b",
                 i, state, pc, reg_write_en, in_delay_slot, m_pc, exp_ds);
      end
      @(negedge clk);
    end
    // WRITEBACK: stray jump/stall inputs must be ignored
    stall_req = 1'($urandom_range(0, 1));
    jump_en = 1'b1; jump_in = 1'b1; jump_target = ~tgt;
    #1;
    n_checks++;
    if (state !== 4'h3 || reg_write_en !== 1'b1 || mem_read !== 1'b0 || ir_write !== 1'b0 ||
        pc !== m_pc || in_delay_slot !== exp_ds) begin
      n_fail++;
      $display("FAIL writeback: state=%h pc=%h rwe=%b mr=%b ds=%b; need state=3 pc=%h rwe=1 mr=0 ds=%b",
               state, pc, reg_write_en, mem_read, in_delay_slot, m_pc, exp_ds);
    end
    if (DS) begin
      if (m_ds) begin
        apply = 1'b1; new_pc = m_tgt; m_pend = 1'b0; m_ds = 1'b0;
      end else begin
        apply = 1'b0; new_pc = m_pc + 32'd4;
        if (jmp && !m_pend) begin m_pend = 1'b1; m_tgt = tgt; end
        m_ds = m_pend;
      end
    end else begin
      apply = jmp;
      new_pc = jmp ? tgt : m_pc + 32'd4;
    end
    m_halt = apply && (new_pc == 32'd0);
    m_pc = new_pc;
    exp_st = m_halt ? 4'hF : 4'h0;
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if (pc !== m_pc || state !== exp_st || active !== !m_halt) begin
      n_fail++;
      $display("FAIL retire: pc=%h state=%h act=%b; need pc=%h state=%h act=%b",
               pc, state, active, m_pc, exp_st, !m_halt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_waitrequest = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'h0 || pc !== RV || in_delay_slot !== 1'b0 || active !== 1'b1 ||
        mem_read !== 1'b1 || ir_write !== 1'b0 || reg_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%h pc=%h ds=%b act=%b mr=%b irw=%b rwe=%b; need 0 %h 0 1 1 0 0",
               state, pc, in_delay_slot, active, mem_read, ir_write, reg_write_en, RV);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_sequential();
    test_reset();
    for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_waitrequest();
    test_reset();
    run_instr(3, 0, 1'b0, 32'd0);
    run_instr(1, 0, 1'b0, 32'd0);
  endtask

  task automatic test_jump();
    test_reset();
    run_instr(0, 0, 1'b1, 32'hBFC00100);
    run_instr(0, 0, 1'b0, 32'd0);
    run_instr(0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_stall();
    test_reset();
    run_instr(0, 5, 1'b1, 32'hBFC00200);
    run_instr(0, 2, 1'b1, 32'h00001000);
    run_instr(0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_halt();
    test_reset();
    run_instr(0, 0, 1'b0, 32'd0);
    run_instr(0, 0, 1'b1, 32'd0);
    if (!m_halt) run_instr(0, 0, 1'b0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      mem_waitrequest = 1'($urandom_range(0, 1));
      jump_en = 1'b1; jump_in = 1'b1; jump_target = 32'h00000040;
      @(negedge clk);
      n_checks++;
      if (state !== 4'hF || active !== 1'b0 || mem_read !== 1'b0 || ir_write !== 1'b0 ||
          reg_write_en !== 1'b0 || pc !== m_pc) begin
        n_fail++;
        $display("FAIL halt[%0d]: state=%h act=%b mr=%b irw=%b rwe=%b pc=%h; need F 0 0 0 0 %h",
                 k, state, active, mem_read, ir_write, reg_write_en, pc, m_pc);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_exec();
    test_reset();
    run_instr(0, 0, 1'b1, 32'hBFC00300);
    @(negedge clk);
    @(negedge clk);
    stall_req = 1'b1;
    #2;
    mem_waitrequest = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'h0 || pc !== RV || in_delay_slot !== 1'b0 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_exec: state=%h pc=%h ds=%b mr=%b; need 0 %h 0 1",
               state, pc, in_delay_slot, mem_read, RV);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    model_reset();
    run_instr(0, 0, 1'b0, 32'd0);
    run_instr(0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] t;
    test_reset();
    for (int k = 0; k < 25; k++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      if (t == 32'd0) t = 32'h00000100;
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), t);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_waitrequest();
    test_jump();
    test_stall();
    test_halt();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
